// File: rtl/fp_norm_round.sv
// fp_norm_round
// Multi-cycle normalize-and-round stage for the binary32 multiplier. Takes
// the raw 48-bit significand product, the sign and the signed biased
// exponent sum. It normalizes with one 1-bit shift per cycle, rounds to
// nearest-even, handles overflow, subnormal and special results, and packs
// a binary32 result into sonuc. Only one operation is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operand valid           in_ready  stage idle, can accept
//   in_sign    result sign             in_exp    signed biased exponent e1+e2-127
//   in_mant    24x24 significand product (hidden bits included)
//   in_nan / in_inf / in_zero          upstream special-case indications
//   out_valid  result valid            out_ready consumer accepts
//   sonuc      packed binary32 result
//   out_flags  {invalid, overflow, underflow, inexact}
//
// Value convention inside the stage: value = m/2^46 * 2^(e-127), and the
// significand is normalized when m[46] is set.
module fp_norm_round #(
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [47:0]             in_mant,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             sonuc,
  output logic [3:0]              out_flags
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  localparam logic signed [EXP_W-1:0] E_ONE = EXP_W'(1);
  // First exponent that no longer fits a finite binary32 (255 for BIAS=127).
  localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(2 * BIAS + 1);

  state_t                    state_q, state_d;
  logic [47:0]               m_q, m_d;
  logic signed [EXP_W-1:0]   e_q, e_d;
  logic                      sign_q, sign_d;
  logic [31:0]               sonuc_q, sonuc_d;
  logic [3:0]                flags_q, flags_d;

  // Rounding datapath, only meaningful while in ROUND.
  logic                      rnd_lsb, rnd_g, rnd_s, rnd_inc, rnd_inexact;
  logic [24:0]               rnd_r;
  logic signed [EXP_W-1:0]   rnd_exp;
  logic [22:0]               rnd_frac;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign sonuc     = sonuc_q;
  assign out_flags = flags_q;

  // Round to nearest-even on the 24 kept bits m[46:23]. A carry out of the
  // significand bumps the exponent; a result with no hidden bit can only
  // arise with e==1 and is packed as a subnormal (exponent field 0).
  always_comb begin
    rnd_lsb     = m_q[23];
    rnd_g       = m_q[22];
    rnd_s       = |m_q[21:0];
    rnd_inc     = rnd_g & (rnd_s | rnd_lsb);
    rnd_inexact = rnd_g | rnd_s;
    rnd_r       = {1'b0, m_q[46:23]} + {24'b0, rnd_inc};
    if (rnd_r[24]) begin
      rnd_exp  = e_q + E_ONE;
      rnd_frac = 23'b0;
    end else if (rnd_r[23]) begin
      rnd_exp  = e_q;
      rnd_frac = rnd_r[22:0];
    end else begin
      rnd_exp  = '0;
      rnd_frac = rnd_r[22:0];
    end
  end

  // Next-state and datapath control. Specials bypass normalization and go
  // straight to OUT. NORM performs one shift per cycle: right shifts keep a
  // sticky bit in m[0] so no discarded bit is lost for rounding, and they
  // also lift tiny exponents up to 1 (the subnormal range).
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    sign_d  = sign_q;
    sonuc_d = sonuc_q;
    flags_d = flags_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          m_d     = in_mant;
          e_d     = in_exp;
          flags_d = 4'b0000;
          if (in_nan) begin
            sonuc_d = 32'h7FC0_0000;
            flags_d = 4'b1000;
            state_d = OUT;
          end else if (in_inf) begin
            sonuc_d = {in_sign, 8'hFF, 23'b0};
            state_d = OUT;
          end else if (in_zero || (in_mant == 48'b0)) begin
            sonuc_d = {in_sign, 31'b0};
            state_d = OUT;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (m_q[47] || (e_q < E_ONE)) begin
          m_d = {1'b0, m_q[47:2], m_q[1] | m_q[0]};
          e_d = e_q + E_ONE;
        end else if (!m_q[46] && (e_q > E_ONE)) begin
          m_d = {m_q[46:0], 1'b0};
          e_d = e_q - E_ONE;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (rnd_exp >= E_MAX) begin
          sonuc_d = {sign_q, 8'hFF, 23'b0};
          flags_d = 4'b0101;
        end else begin
          sonuc_d = {sign_q, rnd_exp[7:0], rnd_frac};
          flags_d = {2'b00, rnd_inexact && (rnd_exp == '0), rnd_inexact};
        end
        state_d = OUT;
      end

      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      sonuc_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      sonuc_q <= sonuc_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round
// Directed vectors for fp_norm_round with hand-computed results and
// latencies, plus hand-written backpressure and mid-operation reset sequences.
module tb_fp_norm_round;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [47:0]       in_mant;
  logic              in_nan;
  logic              in_inf;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       sonuc;
  logic [3:0]        out_flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string             name;
    logic              sign;
    logic signed [9:0] ex;
    logic [47:0]       mant;
    logic              nan;
    logic              inf;
    logic              zero;
    logic [31:0]       exp_sonuc;
    logic [3:0]        exp_flags;
    int                exp_lat;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  fp_norm_round #(.EXP_W(10), .BIAS(127)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sonuc     (sonuc),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Present one operation at a negedge and let it be accepted at the next posedge.
  task automatic acceptOp(input vec_t v);
    @(negedge clk);
    in_sign  = v.sign;
    in_exp   = v.ex;
    in_mant  = v.mant;
    in_nan   = v.nan;
    in_inf   = v.inf;
    in_zero  = v.zero;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges after the accept edge until out_valid appears.
  task automatic waitResult(output int lat, output bit timed_out);
    lat       = 0;
    timed_out = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat       = c;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int lat, output bit timed_out);
    acceptOp(v);
    waitResult(lat, timed_out);
  endtask

  task automatic releaseOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    bit to;
    applyStimulus(v, lat, to);
    if (to) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: out_valid never rose within 200 cycles", v.name);
    end else begin
      checkOutput({v.name, " sonuc"}, sonuc, v.exp_sonuc);
      checkOutput({v.name, " flags"}, {28'b0, out_flags}, {28'b0, v.exp_flags});
      checkOutput({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    end
    releaseOutput();
  endtask

  initial begin
    int  lat;
    bit  to;
    logic [31:0] held;

    vecs[0]  = '{"mul1p5",     1'b0,  10'sd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 4'b0000, 3};
    vecs[1]  = '{"tie_up",     1'b0,  10'sd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 4'b0001, 2};
    vecs[2]  = '{"tie_down",   1'b0,  10'sd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0001, 2};
    vecs[3]  = '{"ovf_pos",    1'b0,  10'sd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 4'b0101, 3};
    vecs[4]  = '{"ovf_neg",    1'b1,  10'sd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 4'b0101, 3};
    vecs[5]  = '{"sub_exact",  1'b0,  10'sd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 4'b0000, 3};
    vecs[6]  = '{"sub_flush",  1'b0, -10'sd30,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0011, 33};
    vecs[7]  = '{"nan",        1'b0,  10'sd127, 48'h9000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h7FC0_0000, 4'b1000, 1};
    vecs[8]  = '{"zero_neg",   1'b1,  10'sd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 4'b0000, 1};
    vecs[9]  = '{"inf_pos",    1'b0,  10'sd127, 48'h9000_0000_0000, 1'b0, 1'b1, 1'b0, 32'h7F80_0000, 4'b0000, 1};
    vecs[10] = '{"inf_neg",    1'b1,  10'sd127, 48'h0,              1'b0, 1'b1, 1'b0, 32'hFF80_0000, 4'b0000, 1};
    vecs[11] = '{"nan_and_inf",1'b1,  10'sd127, 48'h0,              1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 4'b1000, 1};
    vecs[12] = '{"mant_zero",  1'b1,  10'sd127, 48'h0,              1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b0000, 1};
    vecs[13] = '{"rnd_carry",  1'b0,  10'sd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 4'b0001, 2};
    vecs[14] = '{"shift_left", 1'b0,  10'sd130, 48'h1000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 4'b0000, 4};
    vecs[15] = '{"sticky",     1'b0,  10'sd127, 48'h8000_0080_0001, 1'b0, 1'b0, 1'b0, 32'h4000_0001, 4'b0001, 3};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;

    #12;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("reset sonuc",     sonuc,              32'h0);
    checkOutput("reset flags",     {28'b0, out_flags}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      runVector(vecs[i]);
    end

    // Backpressure: result must hold while out_ready is low, and new
    // operands offered during OUT must be ignored.
    applyStimulus(vecs[0], lat, to);
    if (to) begin
      checks++;
      errors++;
      $display("[TB] FAIL backpressure timeout: out_valid never rose");
    end
    held = 32'h4010_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_nan   = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("hold sonuc",     sonuc,                       held);
      checkOutput("hold valid_rdy", {30'b0, out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_nan   = 1'b0;
    releaseOutput();
    checkOutput("release in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("release out_valid", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a long normalization aborts it at once.
    acceptOp(vecs[6]);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post-abort idle", {31'b0, out_valid}, 32'd0);
    runVector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
Multi-cycle normalize-and-round stage that sits directly downstream of the single-precision multiplier's mantissa-product step. It consumes the raw 48-bit significand product, the sign and the biased exponent sum. It then normalizes by iterative 1-bit shifts, rounds to nearest-even, handles overflow, subnormal and special cases, and packs an IEEE-754 binary32 result into sonuc. Valid/ready handshake on both sides; one operation in flight.

Parameters:
EXP_W, 10, signed width of in_exp and internal exponent (two's complement)
BIAS, 127, binary32 exponent bias (documentation/check only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input operand valid
in_ready  out  1  stage can accept; equals (state==IDLE)
in_sign  in  1  result sign (sayi1[31]^sayi2[31])
in_exp  in  EXP_W  signed biased exponent: e1+e2-127
in_mant  in  48  product of the two 24-bit significands (hidden bits included)
in_nan  in  1  upstream special: result is NaN (invalid op)
in_inf  in  1  upstream special: result is infinity
in_zero  in  1  upstream special: result is zero
out_valid  out  1  sonuc/out_flags valid
out_ready  in  1  consumer accepts
sonuc  out  32  packed binary32 result
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (reset low, async): state=IDLE, out_valid=0, sonuc=0, out_flags=0, internal m/e cleared; in_ready=1.
- Value convention: value = m/2^46 * 2^(e-127). Normalized means m[46]=1.
- IDLE: on in_valid&&in_ready, latch inputs into m, e, sign, specials.
  - Specials have priority: nan > inf > zero-or-(in_mant==0).
  - Special accepted → go to OUT next edge with: nan → 0x7FC00000 and invalid=1; inf → {sign,0xFF,0}; zero → {sign,31'b0}; other flags 0.
  - Otherwise go to NORM.
- NORM: one action per cycle, checked in this order:
  - (a) m[47]=1 or e<1: m=m>>1 with the shifted-out bit ORed into m[0] (sticky), e=e+1.
  - (b) else m[46]=0 and e>1: m=m<<1, e=e-1.
  - (c) else go to ROUND, no change.
- ROUND: lsb=m[23], g=m[22], s=|m[21:0]; inc=g&(s|lsb); r[24:0]={1'b0,m[46:23]}+inc.
  - r[24]=1: exp=e+1, frac=0.
  - r[23]=1: exp=e, frac=r[22:0].
  - else (subnormal): exp=0, frac=r[22:0].
  - Then if exp>=255: sonuc={sign,0xFF,23'b0}, overflow=1, inexact=1.
  - inexact=g|s. underflow=inexact&&(exp==0).
  - Go to OUT.
- OUT: out_valid=1. sonuc and out_flags are held stable while out_ready=0. On out_ready: out_valid=0, go to IDLE next edge. No new accept while in OUT (no bubble elimination).
- Latency: accept edge → out_valid high after k+2 edges, where k = number of NORM shift cycles. Specials: 1 edge.
- Bound on k: max 48 + |e| cycles. No timeout.
- in_* are ignored when in_ready=0.
- Reset low in any state aborts the operation immediately: out_valid drops, the in-flight result is discarded.
- Exponent arithmetic is EXP_W signed. Wrap is impossible for in_exp in [-400, 400]; the bench keeps inputs within this range.

Test Plan:
- 1.5*1.5: in_mant=0x900000000000, in_exp=127, sign=0 → k=1, out_valid 3 edges after accept, sonuc=0x40100000, flags=0.
- Tie-to-even up: in_mant=0x400000C00000, in_exp=127 → sonuc=0x3F800002, flags=0001. Same with in_mant=0x400000400000 → sonuc=0x3F800000, flags=0001.
- Overflow: in_mant=0x800000000000, in_exp=254 → sonuc=0x7F800000, flags=0101. With sign=1 → 0xFF800000.
- Subnormal exact: in_mant=0x400000000000, in_exp=0 → k=1, sonuc=0x00400000, flags=0000. With in_exp=-30 → sonuc=0x00000000, flags=0011.
- Specials: in_nan=1 → sonuc=0x7FC00000, flags=1000, out_valid after 1 edge. in_zero=1 with sign=1 → 0x80000000. in_inf=1 → 0x7F800000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → sonuc/out_valid stable, in_ready=0.
  - Release → in_ready=1 next cycle.
  - Pull reset low during NORM → out_valid=0 and in_ready=1 immediately.
  - After reset, a fresh 1.5*1.5 returns 0x40100000.
